// File: rtl/im_fetch_pkg.sv
// Shared constants for the instruction-memory fetch path.
// The IM geometry macros normally come from the shared include; defaults keep standalone builds working.
`ifndef INS_RAM_DEPTH
`define INS_RAM_DEPTH 16
`endif
`ifndef INS_RAM_DATA_WIDTH
`define INS_RAM_DATA_WIDTH 32
`endif

package im_fetch_pkg;
  localparam int IM_DEPTH      = `INS_RAM_DEPTH;
  localparam int IM_AW         = $clog2(`INS_RAM_DEPTH);
  localparam int IM_DW         = `INS_RAM_DATA_WIDTH;
  localparam int IM_RD_LATENCY = 2;
  localparam int IM_FIFO_DEPTH = 8;
endpackage

// File: rtl/im_fetch_if.sv
// Bundle of control, IM read-port and decoder-stream signals of im_fetch.
// master = fetch block side, slave = environment (IM + decoder + sequencer) side.
interface im_fetch_if import im_fetch_pkg::*; #(
  parameter int ADDR_WIDTH = IM_AW,
  parameter int DATA_WIDTH = IM_DW
);
  logic                  start_pulse;
  logic [ADDR_WIDTH:0]   n_ins;
  logic                  busy;
  logic                  done_pulse;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] dout;
  logic [DATA_WIDTH-1:0] ins_data;
  logic                  ins_valid;
  logic                  ins_ready;

  modport master (
    input  start_pulse, n_ins, dout, ins_ready,
    output busy, done_pulse, rd_en, rd_addr, ins_data, ins_valid
  );
  modport slave (
    output start_pulse, n_ins, dout, ins_ready,
    input  busy, done_pulse, rd_en, rd_addr, ins_data, ins_valid
  );
endinterface

// File: rtl/im_fetch_fifo.sv
// First-word-fall-through FIFO: head_o shows the oldest entry whenever count_o != 0.
// Head is forced to zero when empty so the consumer never sees stale words.
module im_fetch_fifo import im_fetch_pkg::*; #(
  parameter int WIDTH = IM_DW,
  parameter int DEPTH = IM_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       din_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       head_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_C = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + {{PW{1'b0}}, push_i} - {{PW{1'b0}}, pop_i};
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

  assign head_o  = (cnt_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count_o = cnt_q;

  // Upstream credit accounting must make these unreachable.
  a_no_overflow:  assert property (@(posedge clk) disable iff (!rst_n) !(push_i && !pop_i && cnt_q == FULL_C));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(pop_i && cnt_q == '0));
endmodule

// File: rtl/im_fetch.sv
// Streams n_ins words from IM address 0 into the decoder through a credit-limited prefetch FIFO.
// Reads are only issued when the FIFO is guaranteed room for every outstanding return.
module im_fetch import im_fetch_pkg::*; #(
  parameter int ADDR_WIDTH = IM_AW,
  parameter int DATA_WIDTH = IM_DW,
  parameter int RD_LATENCY = IM_RD_LATENCY,
  parameter int FIFO_DEPTH = IM_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       rst_n,
  im_fetch_if.master bus
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   n_q, n_d, iss_q, iss_d, acc_q, acc_d;
  logic                  rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [RD_LATENCY-1:0] vld_pipe_q;
  logic [CW-1:0]         inflight_q, inflight_d, fifo_cnt;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  push, hs;
  logic [CW:0]           credit_used;

  assign push = vld_pipe_q[RD_LATENCY-1];
  assign hs   = bus.ins_valid & bus.ins_ready;
  // A pop this cycle frees a slot the next read can already claim.
  assign credit_used = {1'b0, inflight_q} + {1'b0, fifo_cnt} - {{CW{1'b0}}, hs};

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    iss_d     = iss_q;
    acc_d     = acc_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    case (state_q)
      S_IDLE: if (bus.start_pulse) begin
        n_d   = bus.n_ins;
        iss_d = '0;
        acc_d = '0;
        if (bus.n_ins == '0) begin
          state_d = S_DONE;
        end else begin
          state_d   = S_RUN;
          rd_en_d   = 1'b1;
          rd_addr_d = '0;
          iss_d     = {{ADDR_WIDTH{1'b0}}, 1'b1};
        end
      end
      S_RUN: begin
        if (iss_q < n_q && credit_used < DEPTH_C) begin
          rd_en_d   = 1'b1;
          rd_addr_d = iss_q[ADDR_WIDTH-1:0];
          iss_d     = iss_q + 1'b1;
        end
        if (hs) begin
          acc_d = acc_q + 1'b1;
          if (acc_d == n_q) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign inflight_d = inflight_q + {{(CW-1){1'b0}}, rd_en_d} - {{(CW-1){1'b0}}, push};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      iss_q      <= '0;
      acc_q      <= '0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      vld_pipe_q <= '0;
      inflight_q <= '0;
    end else begin
      state_q       <= state_d;
      n_q           <= n_d;
      iss_q         <= iss_d;
      acc_q         <= acc_d;
      rd_en_q       <= rd_en_d;
      rd_addr_q     <= rd_addr_d;
      inflight_q    <= inflight_d;
      vld_pipe_q[0] <= rd_en_q;
      for (int i = 1; i < RD_LATENCY; i++) vld_pipe_q[i] <= vld_pipe_q[i-1];
    end
  end

  im_fetch_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .din_i   (bus.dout),
    .pop_i   (hs),
    .head_o  (fifo_head),
    .count_o (fifo_cnt)
  );

  assign bus.rd_en      = rd_en_q;
  assign bus.rd_addr    = rd_addr_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done_pulse = (state_q == S_DONE);
  assign bus.ins_valid  = (fifo_cnt != '0);
  assign bus.ins_data   = fifo_head;
endmodule
